// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
//  Module      : memory_stage
//  Description : Pipeline MEM stage. It captures the execute-stage result in
//                an EX/MEM register. Loads and stores run over a multi-cycle
//                request/ready data-memory bus. The stage aligns store data
//                into byte lanes and extracts and extends load data. It
//                registers the result toward write-back, stalls the upstream
//                pipeline while an access is outstanding, and drives the
//                MEM-side forwarding data.
//  Revision    : 1.0  initial release
// ============================================================================
module memory_stage #(
    parameter int DMEM_TIMEOUT = 16             // legal range 2..255
) (
    input  logic        clk,
    input  logic        reset_n,

    // execute-stage handoff
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] alu_data,
    input  logic [31:0] memory_data,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_funct3,

    // forwarding toward execute
    output logic [31:0] mem_forward_data,
    output logic [4:0]  mem_rd,
    output logic        mem_reg_write,
    output logic        stall,

    // data-memory bus
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,

    // write-back
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        exc_misaligned,
    output logic        exc_bus_timeout
);

    // Last count value at which a BUSY cycle without ready aborts the access.
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(DMEM_TIMEOUT - 1);

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;

    // EX/MEM register
    logic        r_valid;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic        r_rd_en;
    logic        r_wr_en;
    logic [2:0]  r_funct3;

    logic        w_busy;
    logic        w_ex_is_mem;
    logic        w_ex_bad;
    logic        w_held_mem;
    logic        w_held_bad;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_load_byte;
    logic [15:0] w_load_half;
    logic [31:0] w_load_data;

    // A memory access is rejected (no bus request) when its size is not
    // naturally aligned or its funct3 encodes no legal RV32I load/store.
    function automatic logic f_bad_access(
        input logic       is_store,
        input logic [2:0] funct3,
        input logic [1:0] lane
    );
        logic bad;
        bad = 1'b0;
        case (funct3)
            c_F3_B:  bad = 1'b0;
            c_F3_H:  bad = lane[0];
            c_F3_W:  bad = |lane;
            c_F3_BU: bad = is_store;
            c_F3_HU: bad = is_store | lane[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign w_busy      = (r_state == ST_BUSY);
    assign w_ex_is_mem = ex_valid & (mem_read | mem_write);
    assign w_ex_bad    = f_bad_access(mem_write, mem_funct3, alu_data[1:0]);
    assign w_held_mem  = r_rd_en | r_wr_en;
    assign w_held_bad  = f_bad_access(r_wr_en, r_funct3, r_addr[1:0]);

    assign ex_ready = ~w_busy;
    assign stall    = w_busy;

    // Loads never forward: their data only exists after the bus returns.
    assign mem_forward_data = r_addr;
    assign mem_rd           = r_rd;
    assign mem_reg_write    = r_valid & r_reg_write & ~r_rd_en;

    // Bus outputs are only driven while an access is outstanding.
    assign dmem_req   = w_busy;
    assign dmem_we    = w_busy & r_wr_en;
    assign dmem_addr  = w_busy ? {r_addr[31:2], 2'b00} : 32'h0;
    assign dmem_wdata = (w_busy & r_wr_en) ? w_wdata : 32'h0;
    assign dmem_be    = (w_busy & r_wr_en) ? w_be : 4'b0000;

    // Store lane steering: replicate the datum across the word, enable lanes.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = r_sdata;
        case (r_funct3)
            c_F3_B: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_sdata[7:0]}};
            end
            c_F3_H: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_sdata[15:0]}};
            end
            c_F3_W: begin
                w_be    = 4'b1111;
                w_wdata = r_sdata;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = r_sdata;
            end
        endcase
    end

    // Load extraction: select the addressed byte/halfword and extend it.
    always_comb begin
        w_load_byte = dmem_rdata[{r_addr[1:0], 3'b000} +: 8];
        w_load_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        w_load_data = dmem_rdata;
        case (r_funct3)
            c_F3_B:  w_load_data = {{24{w_load_byte[7]}}, w_load_byte};
            c_F3_H:  w_load_data = {{16{w_load_half[15]}}, w_load_half};
            c_F3_W:  w_load_data = dmem_rdata;
            c_F3_BU: w_load_data = {24'h0, w_load_byte};
            c_F3_HU: w_load_data = {16'h0, w_load_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    // EX/MEM register: refilled on every edge the stage is accepting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid     <= 1'b0;
            r_addr      <= 32'h0;
            r_sdata     <= 32'h0;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_rd_en     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_funct3    <= 3'b000;
        end else if (ex_ready) begin
            r_valid     <= ex_valid;
            r_addr      <= alu_data;
            r_sdata     <= memory_data;
            r_rd        <= rd;
            r_reg_write <= reg_write;
            r_rd_en     <= mem_read;
            r_wr_en     <= mem_write;
            r_funct3    <= mem_funct3;
        end
    end

    // Access FSM, timeout counter and registered write-back outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_cnt           <= 8'd0;
            wb_valid        <= 1'b0;
            wb_rd           <= 5'd0;
            wb_reg_write    <= 1'b0;
            wb_data         <= 32'h0;
            exc_misaligned  <= 1'b0;
            exc_bus_timeout <= 1'b0;
        end else begin
            wb_valid        <= 1'b0;
            exc_misaligned  <= 1'b0;
            exc_bus_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A held aligned memory op in IDLE has already completed;
                    // only non-memory and rejected ops retire from here.
                    if (r_valid && (!w_held_mem || w_held_bad)) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= r_rd;
                        wb_data  <= r_addr;
                        if (w_held_mem) begin
                            wb_reg_write   <= 1'b0;
                            exc_misaligned <= 1'b1;
                        end else begin
                            wb_reg_write <= r_reg_write;
                        end
                    end
                    if (w_ex_is_mem && !w_ex_bad) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= 8'd0;
                    end
                end
                ST_BUSY: begin
                    if (dmem_ready) begin
                        wb_valid     <= 1'b1;
                        wb_rd        <= r_rd;
                        wb_reg_write <= r_reg_write & ~r_wr_en;
                        wb_data      <= r_wr_en ? r_addr : w_load_data;
                        r_state      <= ST_IDLE;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        wb_valid        <= 1'b1;
                        wb_rd           <= r_rd;
                        wb_reg_write    <= 1'b0;
                        wb_data         <= r_addr;
                        exc_bus_timeout <= 1'b1;
                        r_state         <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_stage
//  Description : Directed self-checking bench for memory_stage. Expected
//                write-back records are queued as stimulus is driven and
//                compared when the stage retires them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] alu_data;
    logic [31:0] memory_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_forward_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        exc_misaligned;
    logic        exc_bus_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
        logic        chk_data;
        logic        mis;
        logic        to;
    } wb_exp_t;

    wb_exp_t exp_q[$];

    memory_stage #(.DMEM_TIMEOUT(16)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .alu_data         (alu_data),
        .memory_data      (memory_data),
        .rd               (rd),
        .reg_write        (reg_write),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_funct3       (mem_funct3),
        .mem_forward_data (mem_forward_data),
        .mem_rd           (mem_rd),
        .mem_reg_write    (mem_reg_write),
        .stall            (stall),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_be          (dmem_be),
        .dmem_rdata       (dmem_rdata),
        .dmem_ready       (dmem_ready),
        .wb_valid         (wb_valid),
        .wb_rd            (wb_rd),
        .wb_reg_write     (wb_reg_write),
        .wb_data          (wb_data),
        .exc_misaligned   (exc_misaligned),
        .exc_bus_timeout  (exc_bus_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                            input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
        ex_valid    = 1'b1;
        alu_data    = a;
        memory_data = d;
        rd          = r;
        reg_write   = rw;
        mem_read    = mr;
        mem_write   = mw;
        mem_funct3  = f3;
    endtask

    task automatic clear_ex();
        ex_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
    endtask

    task automatic push_exp(input logic [4:0] r, input logic rw, input logic [31:0] d,
                            input logic cd, input logic mis, input logic to);
        wb_exp_t e;
        e.rd = r; e.rw = rw; e.data = d; e.chk_data = cd; e.mis = mis; e.to = to;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every retirement must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n && wb_valid) begin
            chkb("wb_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                wb_exp_t e;
                e = exp_q.pop_front();
                chk ("wb_rd", 32'(wb_rd), 32'(e.rd));
                chkb("wb_reg_write", wb_reg_write, e.rw);
                if (e.chk_data) chk("wb_data", wb_data, e.data);
                chkb("exc_misaligned", exc_misaligned, e.mis);
                chkb("exc_bus_timeout", exc_bus_timeout, e.to);
            end
        end
    end

    // Load through the bus with ready on the first request cycle.
    task automatic quick_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] r,
                              input logic [31:0] rdata, input logic [31:0] exp_data, input string tag);
        drive_ex(a, 32'h0, r, 1'b1, 1'b1, 1'b0, f3);
        push_exp(r, 1'b1, exp_data, 1'b1, 1'b0, 1'b0);
        tick();
        clear_ex();
        chkb({tag, "_req"}, dmem_req, 1'b1);
        chk ({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
        chk ({tag, "_be"}, 32'(dmem_be), 32'h0);
        chkb({tag, "_fwd_rw"}, mem_reg_write, 1'b0);
        dmem_rdata = rdata;
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        chkb({tag, "_req_drop"}, dmem_req, 1'b0);
        chkb({tag, "_ex_ready"}, ex_ready, 1'b1);
    endtask

    initial begin
        int req_cycles;
        reset_n    = 1'b0;
        dmem_rdata = 32'h0;
        dmem_ready = 1'b0;
        alu_data   = 32'h0;
        memory_data = 32'h0;
        rd         = 5'd0;
        mem_funct3 = 3'b000;
        clear_ex();

        // Reset state
        tick();
        tick();
        chkb("rst_ex_ready", ex_ready, 1'b1);
        chkb("rst_stall", stall, 1'b0);
        chkb("rst_req", dmem_req, 1'b0);
        chk ("rst_addr", dmem_addr, 32'h0);
        chkb("rst_wb_valid", wb_valid, 1'b0);
        chk ("rst_wb_data", wb_data, 32'h0);
        chk ("rst_fwd", mem_forward_data, 32'h0);
        chkb("rst_fwd_rw", mem_reg_write, 1'b0);
        reset_n = 1'b1;
        tick();

        // Non-memory instruction retires one edge after capture
        drive_ex(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
        push_exp(5'd5, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
        tick();
        clear_ex();
        chk ("add_fwd", mem_forward_data, 32'h0000_1234);
        chk ("add_fwd_rd", 32'(mem_rd), 32'd5);
        chkb("add_fwd_rw", mem_reg_write, 1'b1);
        chkb("add_req", dmem_req, 1'b0);
        chkb("add_wb_early", wb_valid, 1'b0);
        tick();
        chkb("add_req2", dmem_req, 1'b0);
        tick();
        chkb("add_bubble", wb_valid, 1'b0);

        // Byte and halfword loads, signed and unsigned
        quick_load(32'h0000_0103, 3'b000, 5'd6, 32'h80FF_FF7F, 32'hFFFF_FF80, "lb");
        quick_load(32'h0000_0103, 3'b100, 5'd7, 32'h80FF_FF7F, 32'h0000_0080, "lbu");
        quick_load(32'h0000_0102, 3'b001, 5'd11, 32'h8001_7FFF, 32'hFFFF_8001, "lh");
        quick_load(32'h0000_0100, 3'b101, 5'd12, 32'h8001_7FFF, 32'h0000_7FFF, "lhu");
        quick_load(32'h0000_0104, 3'b010, 5'd13, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "lw");

        // SH with ready delayed: request held stable four cycles
        drive_ex(32'h0000_0202, 32'hABCD_5678, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001);
        push_exp(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        clear_ex();
        for (int i = 0; i < 4; i++) begin
            chkb("sh_req", dmem_req, 1'b1);
            chkb("sh_we", dmem_we, 1'b1);
            chk ("sh_addr", dmem_addr, 32'h0000_0200);
            chk ("sh_be", 32'(dmem_be), 32'hC);
            chk ("sh_wdata", dmem_wdata, 32'h5678_5678);
            chkb("sh_stall", stall, 1'b1);
            if (i == 3) dmem_ready = 1'b1;
            tick();
        end
        dmem_ready = 1'b0;
        chkb("sh_ex_ready", ex_ready, 1'b1);
        chkb("sh_stall_off", stall, 1'b0);

        // Ready while idle must be ignored
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        chkb("idle_ready_req", dmem_req, 1'b0);
        chkb("idle_ready_wb", wb_valid, 1'b0);

        // SB lane steering
        drive_ex(32'h0000_0011, 32'h1234_56A5, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000);
        push_exp(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        clear_ex();
        chk ("sb_be", 32'(dmem_be), 32'h2);
        chk ("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        chk ("sb_addr", dmem_addr, 32'h0000_0010);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;

        // Misaligned LW: no request, exception pulse
        drive_ex(32'h0000_0301, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010);
        push_exp(5'd8, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        clear_ex();
        chkb("mis_req", dmem_req, 1'b0);
        chkb("mis_stall", stall, 1'b0);
        tick();
        chkb("mis_req2", dmem_req, 1'b0);
        tick();
        chkb("mis_pulse_end", exc_misaligned, 1'b0);

        // Bus timeout: request held for exactly DMEM_TIMEOUT cycles
        drive_ex(32'h0000_0400, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b010);
        push_exp(5'd9, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        clear_ex();
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!dmem_req) break;
            req_cycles++;
            tick();
        end
        chk ("to_req_cycles", 32'(req_cycles), 32'd16);
        chkb("to_idle", ex_ready, 1'b1);
        tick();
        chkb("to_pulse_end", exc_bus_timeout, 1'b0);

        // Reset during BUSY drops the access immediately
        drive_ex(32'h0000_0500, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 3'b010);
        tick();
        clear_ex();
        tick();
        chkb("rb_req_before", dmem_req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chkb("rb_req", dmem_req, 1'b0);
        chkb("rb_wb_valid", wb_valid, 1'b0);
        chkb("rb_stall", stall, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();

        drive_ex(32'h0000_CAFE, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 3'b000);
        push_exp(5'd10, 1'b1, 32'h0000_CAFE, 1'b1, 1'b0, 1'b0);
        tick();
        clear_ex();
        tick();
        tick();
        tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
